// File: rtl/arb_pkg.sv
// Shared arbitration constants and helpers for arbitrated datapath blocks.
package arb_pkg;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Index width for an n-way select; never narrower than one bit.
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arb_rr.sv
// Request arbiter: one-hot grant plus encoded index, round-robin or fixed priority.
module arb_rr
   import arb_pkg::*;
#(
   parameter  int CHANNELS = 4,
   parameter  int RR_MODE  = ARB_RR,
   localparam int SEL_W    = sel_w(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] valid_i,
   input  logic                adv_i,
   output logic [CHANNELS-1:0] grant_o,
   output logic [SEL_W-1:0]    idx_o
);

   logic [SEL_W-1:0]    ptr_q, ptr_d;
   logic [CHANNELS-1:0] upper;
   logic [CHANNELS-1:0] pick;
   logic                found;

   // Requests at or above ptr win first; otherwise wrap to the lowest request.
   always_comb begin
      upper   = '0;
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         upper[i] = valid_i[i] && (i >= 32'(ptr_q));
      end
      pick = (|upper) ? upper : valid_i;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (pick[i] && !found) begin
            found      = 1'b1;
            grant_o[i] = 1'b1;
            idx_o      = SEL_W'(i);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (RR_MODE != ARB_FIXED && adv_i) begin
         if (32'(idx_o) == CHANNELS - 1) begin
            ptr_d = '0;
         end else begin
            ptr_d = idx_o + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/arb_mux.sv
// N-channel registered multiplexer with arbitration and valid/ready handshaking.
module arb_mux
   import arb_pkg::*;
#(
   parameter  int WIDTH    = 4,
   parameter  int CHANNELS = 4,
   parameter  int RR_MODE  = ARB_RR,
   localparam int SEL_W    = sel_w(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic [CHANNELS-1:0]       in_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   input  logic                      out_ready
);

   logic                out_valid_q, out_valid_d;
   logic [WIDTH-1:0]    out_data_q,  out_data_d;
   logic [SEL_W-1:0]    out_chan_q,  out_chan_d;
   logic [CHANNELS-1:0] grant;
   logic [SEL_W-1:0]    grant_idx;
   logic [WIDTH-1:0]    sel_data;
   logic                load;
   logic                any_grant;

   arb_rr #(
      .CHANNELS (CHANNELS),
      .RR_MODE  (RR_MODE)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (in_valid),
      .adv_i   (load && any_grant),
      .grant_o (grant),
      .idx_o   (grant_idx)
   );

   assign load      = !out_valid_q || out_ready;
   assign any_grant = |grant;
   // Gated by rst_n so no producer sees an accept while the block is held in reset.
   assign in_ready  = (load && rst_n) ? grant : '0;

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      if (load) begin
         out_valid_d = any_grant;
         if (any_grant) begin
            out_data_d = sel_data;
            out_chan_d = grant_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: round-robin, fixed-priority and single-channel instances against a queue-free reference model.
module tb_arb_mux;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  in_valid = '0;
   logic [15:0] in_data = '0;
   logic        out_ready = 1'b0;

   logic [3:0]  rdy_rr, rdy_fx;
   logic        rdy_c1;
   logic        ov_rr, ov_fx, ov_c1;
   logic [3:0]  od_rr, od_fx, od_c1;
   logic [1:0]  oc_rr, oc_fx;
   logic [0:0]  oc_c1;

   always #5 clk = ~clk;

   arb_mux #(.WIDTH(4), .CHANNELS(4), .RR_MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy_rr), .out_valid(ov_rr), .out_data(od_rr), .out_chan(oc_rr),
      .out_ready(out_ready));

   arb_mux #(.WIDTH(4), .CHANNELS(4), .RR_MODE(0)) u_fx (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy_fx), .out_valid(ov_fx), .out_data(od_fx), .out_chan(oc_fx),
      .out_ready(out_ready));

   arb_mux #(.WIDTH(4), .CHANNELS(1), .RR_MODE(1)) u_c1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_data(in_data[3:0]),
      .in_ready(rdy_c1), .out_valid(ov_c1), .out_data(od_c1), .out_chan(oc_c1),
      .out_ready(out_ready));

   int total = 0;
   int bad   = 0;

   // Reference model state: one entry per instance (rr, fx, c1).
   int unsigned m_n  [3] = '{4, 4, 1};
   bit          m_rr [3] = '{1'b1, 1'b0, 1'b1};
   string       m_nm [3] = '{"rr", "fx", "c1"};
   bit          m_v  [3];
   int unsigned m_d  [3];
   int unsigned m_c  [3];
   int unsigned m_p  [3];

   logic [3:0] rdy_rr_seen, rdy_fx_seen;

   typedef struct {
      logic [3:0]  v;
      logic [15:0] d;
      logic        rdy;
      logic        ev;
      logic [1:0]  ec;
      logic [3:0]  ed;
      logic [1:0]  efc;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic int mgrant(input int k, input logic [3:0] v);
      for (int unsigned j = 0; j < m_n[k]; j++) begin
         int unsigned c;
         c = (m_p[k] + j) % m_n[k];
         if (v[c]) return int'(c);
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_v[k] = 1'b0; m_d[k] = 0; m_c[k] = 0; m_p[k] = 0;
      end
   endtask

   // One clock: drive at negedge, check in_ready, predict, check registers after the edge.
   task automatic step(input logic rst, input logic [3:0] v, input logic [15:0] d, input logic rdy);
      logic [3:0]  act_rdy [3];
      logic [3:0]  er;
      bit          nv [3];
      int unsigned nd [3];
      int unsigned nc [3];
      int unsigned np [3];
      int          g;
      bit          ld;
      @(negedge clk);
      rst_n = rst; in_valid = v; in_data = d; out_ready = rdy;
      #1;
      act_rdy[0] = rdy_rr; act_rdy[1] = rdy_fx; act_rdy[2] = {3'b000, rdy_c1};
      rdy_rr_seen = rdy_rr; rdy_fx_seen = rdy_fx;
      for (int k = 0; k < 3; k++) begin
         ld = !m_v[k] || rdy;
         g  = mgrant(k, v);
         er = '0;
         if (rst && ld && g >= 0) er[g] = 1'b1;
         check({m_nm[k], "_in_ready"}, 32'(act_rdy[k]), 32'(er));
         nv[k] = m_v[k]; nd[k] = m_d[k]; nc[k] = m_c[k]; np[k] = m_p[k];
         if (!rst) begin
            nv[k] = 1'b0; nd[k] = 0; nc[k] = 0; np[k] = 0;
         end else if (ld) begin
            if (g >= 0) begin
               nv[k] = 1'b1;
               nd[k] = (32'(d) >> (4 * g)) & 32'hF;
               nc[k] = g;
               if (m_rr[k]) np[k] = (g + 1) % m_n[k];
            end else begin
               nv[k] = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         m_v[k] = nv[k]; m_d[k] = nd[k]; m_c[k] = nc[k]; m_p[k] = np[k];
      end
      check("rr_out_valid", 32'(ov_rr), 32'(m_v[0]));
      check("rr_out_data",  32'(od_rr), m_d[0]);
      check("rr_out_chan",  32'(oc_rr), m_c[0]);
      check("fx_out_valid", 32'(ov_fx), 32'(m_v[1]));
      check("fx_out_data",  32'(od_fx), m_d[1]);
      check("fx_out_chan",  32'(oc_fx), m_c[1]);
      check("c1_out_valid", 32'(ov_c1), 32'(m_v[2]));
      check("c1_out_data",  32'(od_c1), m_d[2]);
      check("c1_out_chan",  32'(oc_c1), m_c[2]);
   endtask

   task automatic hand(input string nm, input logic v, input logic [1:0] c, input logic [3:0] d);
      check({nm, "_valid"}, 32'(ov_rr), 32'(v));
      check({nm, "_chan"},  32'(oc_rr), 32'(c));
      check({nm, "_data"},  32'(od_rr), 32'(d));
   endtask

   localparam logic [15:0] D1 = 16'hC953;
   localparam logic [15:0] D2 = 16'hCA53;

   initial begin
      tbl[0] = '{v:4'hF, d:D1, rdy:1'b1, ev:1'b1, ec:2'd0, ed:4'h3, efc:2'd0};
      tbl[1] = '{v:4'hF, d:D1, rdy:1'b1, ev:1'b1, ec:2'd1, ed:4'h5, efc:2'd0};
      tbl[2] = '{v:4'hF, d:D1, rdy:1'b1, ev:1'b1, ec:2'd2, ed:4'h9, efc:2'd0};
      tbl[3] = '{v:4'hF, d:D1, rdy:1'b1, ev:1'b1, ec:2'd3, ed:4'hC, efc:2'd0};
      tbl[4] = '{v:4'hF, d:D1, rdy:1'b1, ev:1'b1, ec:2'd0, ed:4'h3, efc:2'd0};
      tbl[5] = '{v:4'hA, d:D1, rdy:1'b1, ev:1'b1, ec:2'd1, ed:4'h5, efc:2'd1};
      tbl[6] = '{v:4'hA, d:D1, rdy:1'b1, ev:1'b1, ec:2'd3, ed:4'hC, efc:2'd1};
      tbl[7] = '{v:4'hA, d:D1, rdy:1'b1, ev:1'b1, ec:2'd1, ed:4'h5, efc:2'd1};

      model_reset();
      rst_n = 1'b0; in_valid = 4'hF; in_data = D1; out_ready = 1'b1;

      // Reset held with every channel requesting.
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 4'hF, D1, 1'b1);
         hand("reset", 1'b0, 2'd0, 4'h0);
         check("reset_in_ready", 32'(rdy_rr_seen), 32'h0);
      end

      // Round-robin fairness, then fixed priority with 4'b1010.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, tbl[i].v, tbl[i].d, tbl[i].rdy);
         hand($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ec, tbl[i].ed);
         check($sformatf("tbl%0d_fx_chan", i), 32'(oc_fx), 32'(tbl[i].efc));
         if (i >= 5) check($sformatf("tbl%0d_fx_rdy3", i), 32'(rdy_fx_seen[3]), 32'h0);
      end

      // Stall holding channel 2 / data A, then release resumes at channel 3.
      step(1'b1, 4'b0100, D2, 1'b1);
      hand("stall_load", 1'b1, 2'd2, 4'hA);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 4'hF, D2, 1'b0);
         hand("stall_hold", 1'b1, 2'd2, 4'hA);
         check("stall_in_ready", 32'(rdy_rr_seen), 32'h0);
      end
      step(1'b1, 4'hF, D2, 1'b1);
      check("release_in_ready", 32'(rdy_rr_seen), 32'h8);
      hand("release", 1'b1, 2'd3, 4'hC);

      // Wrap from ptr=3 and skip non-requesting channels.
      step(1'b1, 4'b0100, D2, 1'b1);
      hand("wrap_setup", 1'b1, 2'd2, 4'hA);
      step(1'b1, 4'b0101, D2, 1'b1);
      check("wrap_in_ready", 32'(rdy_rr_seen), 32'h1);
      hand("wrap", 1'b1, 2'd0, 4'h3);
      step(1'b1, 4'b0101, D2, 1'b1);
      hand("skip", 1'b1, 2'd2, 4'hA);

      // Asynchronous reset pulse during a stall.
      step(1'b1, 4'hF, D2, 1'b0);
      hand("preburst", 1'b1, 2'd2, 4'hA);
      @(negedge clk);
      in_valid = 4'hF; out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      hand("async_rst", 1'b0, 2'd0, 4'h0);
      check("async_rst_fx_valid", 32'(ov_fx), 32'h0);
      check("async_rst_c1_valid", 32'(ov_c1), 32'h0);
      model_reset();
      step(1'b0, 4'hF, D2, 1'b0);
      step(1'b1, 4'b0100, D2, 1'b1);
      hand("post_rst", 1'b1, 2'd2, 4'hA);
      step(1'b1, 4'hF, D2, 1'b1);
      hand("post_rst_ptr", 1'b1, 2'd3, 4'hC);

      // Random traffic with occasional reset and back-pressure.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0,
              4'($urandom), 16'($urandom),
              ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised N-channel, W-bit registered multiplexer with built-in arbitration and valid/ready handshaking. It replaces the fixed 4:1 combinational select path when several producers compete for one consumer, such as ALU operand sources or result write-back. It picks one requesting channel per cycle, by fixed priority or round-robin, and registers the chosen word and its channel index. It sustains one transfer per cycle under continuous back-pressure-free traffic.

## Interface
- WIDTH, 4, data bits per channel (≥1)
- CHANNELS, 4, number of input channels (≥1)
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
- SEL_W, derived, max(1, clog2(CHANNELS)); not overridable
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  CHANNELS  per-channel request
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  CHANNELS  per-channel accept (combinational)
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  registered selected word
- out_chan  output  SEL_W  index of the channel that supplied out_data
- out_ready  input  1  consumer accept

## Operation
- Reset (async assert, sync-safe deassert handled upstream) forces the following: out_valid=0, out_data=0, out_chan=0, priority pointer ptr=0.
- load = !out_valid || out_ready. The output register may be written only when load=1.
- Grant is one-hot and combinational, and only a channel with in_valid=1 can be granted.
  - RR_MODE=1: first valid channel found searching ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1.
  - RR_MODE=0: lowest-index valid channel; ptr is unused and held at 0.
- in_ready[i] = load && grant[i]. At most one in_ready is high per cycle, and in_ready is never high for a non-requesting channel.
- Input transfer on channel i happens when in_valid[i] && in_ready[i]. On that edge: out_data ← in_data[i], out_chan ← i, out_valid ← 1. In RR mode, ptr ← (i+1) mod CHANNELS, wrapping CHANNELS-1 → 0.
- When load=1 and no channel is valid: out_valid ← 0, and out_data and out_chan hold their last value.
- When load=0 (stall, out_valid=1 and out_ready=0): out_valid, out_data, out_chan and ptr all hold. No in_ready is asserted.
- ptr advances only on an actual input transfer, never on idle or stall cycles.
- CHANNELS=1: grant = in_valid[0], out_chan constant 0, RR logic degenerates to pass-through.
- Producers must hold in_data stable while in_valid=1 and in_ready=0. The block does not latch unaccepted inputs.

## Timing
- Latency: 1 cycle from input transfer to out_valid/out_data.
- Throughput: one word per cycle when out_ready is held at 1.
- Simultaneous output pop and input push in the same cycle (out_valid=1, out_ready=1, a valid input present) is a back-to-back transfer with no bubble.
- Combinational paths:
  - in_valid → in_ready.
  - out_ready → in_ready.
  - There is no combinational path from any input to out_valid, out_data or out_chan.
- Reset asserted mid-stall or mid-burst clears out_valid immediately, without waiting for a clock. Any in-flight word is dropped. Arbitration restarts from channel 0.

## Structure
- Shared package `arb_pkg`:
  - constants ARB_FIXED=0 and ARB_RR=1
  - a clog2-based SEL_W helper function, also to be used by future arbitrated blocks
- Sub-module `arb_rr`, parametrised by CHANNELS and RR_MODE:
  - inputs: in_valid, the advance strobe, clk, rst_n
  - outputs: one-hot grant and encoded index
  - owns ptr
- Top level holds the output register, the load/ready logic and the data select (AND-OR over one-hot grant).

## Test plan
- Reset: assert rst_n=0 with in_valid=4'b1111 → out_valid=0, out_data=0, out_chan=0, in_ready=0 for as long as reset is held.
- RR fairness: WIDTH=4, CHANNELS=4, all valid continuously, in_data=3,5,9,C, out_ready=1 → out_chan sequence 0,1,2,3,0 and out_data 3,5,9,C,3 on consecutive cycles.
- Fixed priority: RR_MODE=0, in_valid=4'b1010 held for 3 cycles → out_chan=1 every cycle; channel 3 never gets in_ready.
- Stall: out_valid=1 holding chan 2 data A, out_ready=0 for 4 cycles with new inputs valid → outputs unchanged, in_ready all 0, ptr unchanged. Release → next grant starts at channel 3.
- Wrap and skip: ptr=3, in_valid=4'b0101 → grant channel 0, then ptr=1 → next grant channel 2.
- Mid-burst reset: reset pulsed while out_valid=1 and out_ready=0 → out_valid drops asynchronously. After release with only channel 2 valid → out_chan=2 one cycle later, then ptr=3.
